load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage access controller that sits directly upstream of the 16 KB data memory, between the EX/MEM pipeline register and writeback. It turns one 64-bit RV64 load or store request (byte, half, word or doubleword) into one or two accesses on the memory's 32-bit word port. It handles byte-lane selection, load extraction and sign/zero extension, and alignment and range checks. It returns a completion beat carrying writeback data.

## Interface
- `AW`, 12: word-address width (4096 x 32-bit words = 16 KB).
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: request present.
- `in_ready`  out  1: request accepted when `in_valid & in_ready`.
- `in_store`  in  1: 1 = store, 0 = load.
- `in_funct3`  in  3: RV64 width/sign code: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
- `in_addr`  in  64: byte address.
- `in_wdata`  in  64: store data, right-aligned.
- `in_rd`  in  5: destination register.
- `mem_en`  out  1: word access this cycle.
- `mem_we`  out  4: byte write enables; bit 3 = byte offset 0.
- `mem_addr`  out  AW: word address, equal to `in_addr[AW+1:2]`.
- `mem_wdata`  out  32: write word.
- `mem_rdata`  in  32: read word, valid the cycle after a read access.
- `out_valid`  out  1: completion present.
- `out_ready`  in  1: completion consumed.
- `out_wb_en`  out  1: write `out_data` to `out_rd`; 1 only for a successful load.
- `out_rd`  out  5: destination register.
- `out_data`  out  64: extended load data; 0 for stores and errors.
- `out_err`  out  1: misaligned, out-of-range or illegal funct3.

## Operation
- Byte order is big-endian, matching the data memory:
  - Byte offset 0 is word bits [31:24].
  - A doubleword at A holds bits [63:32] at word A and bits [31:0] at word A+4.
- FSM states are IDLE, ISSUE0, ISSUE1, WAIT and DONE.
- IDLE
  - `in_ready` = 1; all other outputs hold their reset values.
  - On accept, latch the request.
  - If the request is an error, go to DONE with `out_err` = 1 and make no memory access.
  - Otherwise go to ISSUE0.
- Error conditions:
  - Address not aligned to the access size.
  - `in_addr >= 2^(AW+2)`.
  - A doubleword whose second word is out of range.
  - funct3 = 111.
  - A store with funct3[2] = 1.
- ISSUE0
  - `mem_en` = 1 at the word containing `in_addr`.
  - Go to ISSUE1 for doublewords, otherwise to WAIT.
- ISSUE1
  - `mem_en` = 1 at word + 1.
  - For a load, capture `mem_rdata` as the high word.
  - Go to WAIT.
- WAIT
  - Capture `mem_rdata` as the final word for a load.
  - Form `out_data` and go to DONE.
- DONE
  - `out_valid` = 1; all outputs hold until `out_ready`, then go to IDLE.
- Stores
  - Byte: `in_wdata[7:0]` is replicated to all lanes, and the single `mem_we` bit is selected by offset.
  - Half: the data is replicated to both halves, with `mem_we` = 1100 or 0011.
  - Word: `mem_we` = 1111.
  - Doubleword: ISSUE0 writes `wdata[63:32]` and ISSUE1 writes `wdata[31:0]`.
- Loads
  - Extract the addressed lane(s).
  - Sign-extend for b/h/w and zero-extend for bu/hu/wu.
  - A doubleword is {high, low}.
- `mem_we` = 0 on every read access and whenever `mem_en` = 0.

## Timing
- Reset values:
  - state IDLE, `in_ready` 1.
  - `mem_en` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0.
  - `out_valid` 0, `out_wb_en` 0, `out_rd` 0, `out_data` 0, `out_err` 0.
- Latency from the accept edge to `out_valid`:
  - 3 cycles for b/h/w accesses.
  - 4 cycles for doublewords.
  - 1 cycle for errors.
- Throughput is one request per 4 (or 5) cycles, because `in_ready` = 1 only in IDLE.
- Backpressure: DONE holds indefinitely while `out_ready` = 0. The same-cycle `out_ready` handshake returns to IDLE on the next edge; there is no bypass to a new accept.
- Reset mid-operation forces IDLE and drops `mem_en` and `out_valid` asynchronously. In-flight work is discarded, and a partially written doubleword stays partially written.
- The highest valid word (4095) is legal for b/h/w. A doubleword at byte 16380 is an error.

## Structure
- Package `lsu_pkg`:
  - funct3 constants (`F3_B` to `F3_WU`).
  - State enum.
  - Default `AW`.
- Sub-module `lsu_align`, purely combinational:
  - Store side: offset and funct3 to `mem_we` and lane-replicated `mem_wdata`.
  - Load side: offset, funct3 and words to the extended 64-bit result.
- The FSM and registers stay in `load_store_unit`.

## Test plan
- Store doubleword 0x1122334455667788 at 0x400, then load doubleword 0x400:
  - Writes word 0x100 = 0x11223344 and word 0x101 = 0x55667788.
  - `out_data` = 0x1122334455667788 and `out_wb_en` = 1, 4 cycles after the accept.
- Store byte 0x80 at 0x403, then lb and lbu at 0x403:
  - The store drives `mem_we` = 0001.
  - lb returns 0xFFFFFFFFFFFFFF80; lbu returns 0x80.
- lh at 0x401 and sd at 0x404:
  - 1-cycle completion with `out_err` = 1, `out_wb_en` = 0, and no `mem_en` pulse.
- lw at 0x3FFC returns normally; ld at 0x3FFC and lw at 0x4000 both give `out_err` = 1.
- Hold `out_ready` = 0 for 5 cycles after a lw completes:
  - `out_valid` and `out_data` stay stable and `in_ready` stays 0.
  - The request is accepted on the cycle after the handshake.
- Assert `rst` during ISSUE1 of an sd:
  - `mem_en` drops immediately and state returns to IDLE.
  - Only the high word is written, and `out_valid` never rises.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: default word-address width,
// RV64 funct3 width/sign codes, the controller state encoding and a helper
// that flags addresses not aligned to the access size.
// -----------------------------------------------------------------------------
package lsu_pkg;

    // 4096 x 32-bit words = 16 KB of data memory.
    localparam int LSU_AW = 12;

    // RV64 load/store funct3 codes. Bit 2 selects zero extension on loads.
    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE0,
        ST_ISSUE1,
        ST_WAIT,
        ST_DONE
    } lsu_state_e;

    // funct3[1:0] is the log2 of the access size in bytes.
    function automatic logic misaligned(input logic [2:0] funct3,
                                        input logic [2:0] addr_lo);
        logic bad;
        case (funct3[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr_lo[0];
            2'b10:   bad = |addr_lo[1:0];
            default: bad = |addr_lo;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_if
// Bundles the three channels of the load/store unit:
//   in_*   : request from EX/MEM (valid/ready handshake)
//   mem_*  : 32-bit word port of the data memory (read data one cycle later)
//   out_*  : completion beat towards writeback (valid/ready handshake)
// Modports:
//   slave  : the load/store unit itself
//   master : the environment (pipeline, memory and writeback side)
// -----------------------------------------------------------------------------
interface lsu_if #(
    parameter int AW = lsu_pkg::LSU_AW
) ();

    logic          in_valid;
    logic          in_ready;
    logic          in_store;
    logic [2:0]    in_funct3;
    logic [63:0]   in_addr;
    logic [63:0]   in_wdata;
    logic [4:0]    in_rd;

    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic          out_valid;
    logic          out_ready;
    logic          out_wb_en;
    logic [4:0]    out_rd;
    logic [63:0]   out_data;
    logic          out_err;

    modport slave (
        input  in_valid, in_store, in_funct3, in_addr, in_wdata, in_rd,
        input  mem_rdata, out_ready,
        output in_ready, mem_en, mem_we, mem_addr, mem_wdata,
        output out_valid, out_wb_en, out_rd, out_data, out_err
    );

    modport master (
        output in_valid, in_store, in_funct3, in_addr, in_wdata, in_rd,
        output mem_rdata, out_ready,
        input  in_ready, mem_en, mem_we, mem_addr, mem_wdata,
        input  out_valid, out_wb_en, out_rd, out_data, out_err
    );

endinterface

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane logic for a big-endian 32-bit word port
// (byte offset 0 = word bits [31:24]).
// Ports:
//   funct3_i   : access width/sign code
//   offset_i   : byte offset within the word
//   second_i   : 1 while issuing the second (low) word of a doubleword
//   st_data_i  : right-aligned store data
//   st_we_o    : byte write enables, bit 3 = offset 0
//   st_word_o  : lane-replicated write word
//   ld_hi_i    : high word of a doubleword load
//   ld_lo_i    : the addressed word (low word for a doubleword)
//   ld_data_o  : extracted and sign/zero-extended load result
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic        second_i,
    input  logic [63:0] st_data_i,
    output logic [3:0]  st_we_o,
    output logic [31:0] st_word_o,
    input  logic [31:0] ld_hi_i,
    input  logic [31:0] ld_lo_i,
    output logic [63:0] ld_data_o
);

    // Store side: replicate the data to every lane it may land in, then let
    // the enables pick the lane(s) actually written.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        st_we_o   = 4'b0000;
        st_word_o = 32'h0;
        case (funct3_i)
            F3_B: begin
                st_we_o   = 4'b1000 >> offset_i;
                st_word_o = {4{st_data_i[7:0]}};
            end
            F3_H: begin
                st_we_o   = offset_i[1] ? 4'b0011 : 4'b1100;
                st_word_o = {2{st_data_i[15:0]}};
            end
            F3_W: begin
                st_we_o   = 4'b1111;
                st_word_o = st_data_i[31:0];
            end
            F3_D: begin
                st_we_o   = 4'b1111;
                st_word_o = second_i ? st_data_i[31:0] : st_data_i[63:32];
            end
            default: begin
                st_we_o   = 4'b0000;
                st_word_o = 32'h0;
            end
        endcase
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        case (offset_i)
            2'd0:    ld_byte = ld_lo_i[31:24];
            2'd1:    ld_byte = ld_lo_i[23:16];
            2'd2:    ld_byte = ld_lo_i[15:8];
            default: ld_byte = ld_lo_i[7:0];
        endcase
        ld_half = offset_i[1] ? ld_lo_i[15:0] : ld_lo_i[31:16];
    end

    always_comb begin
        ld_data_o = 64'h0;
        case (funct3_i)
            F3_B:    ld_data_o = {{56{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data_o = {56'h0, ld_byte};
            F3_H:    ld_data_o = {{48{ld_half[15]}}, ld_half};
            F3_HU:   ld_data_o = {48'h0, ld_half};
            F3_W:    ld_data_o = {{32{ld_lo_i[31]}}, ld_lo_i};
            F3_WU:   ld_data_o = {32'h0, ld_lo_i};
            F3_D:    ld_data_o = {ld_hi_i, ld_lo_i};
            F3_ILL:  ld_data_o = 64'h0;
            default: ld_data_o = 64'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Memory-stage access controller in front of the 16 KB data memory. Turns one
// RV64 load/store (b/h/w/d, signed or unsigned) into one or two accesses on
// the 32-bit word port and returns a completion beat with writeback data.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : lsu_if.slave -- request, memory word port and completion channels
// Flow: IDLE -> ISSUE0 -> [ISSUE1 for doublewords] -> WAIT -> DONE -> IDLE,
// or IDLE -> DONE directly for a rejected request (no memory access).
// All outputs are decoded from the registered state, so a reset drops
// mem_en and out_valid immediately.
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int AW = LSU_AW
) (
    input  logic clk,
    input  logic rst,
    lsu_if.slave bus
);

    lsu_state_e    state_q,  state_d;
    logic          store_q,  store_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [AW-1:0] word_q,   word_d;
    logic [1:0]    off_q,    off_d;
    logic [63:0]   wdata_q,  wdata_d;
    logic [4:0]    rd_q,     rd_d;
    logic          err_q,    err_d;
    logic [31:0]   hi_q,     hi_d;
    logic [63:0]   data_q,   data_d;

    logic          req_err;
    logic [3:0]    st_we;
    logic [31:0]   st_word;
    logic [63:0]   ld_data;

    // Request checks, evaluated on the incoming request while in IDLE.
    always_comb begin
        req_err = 1'b0;
        if (bus.in_funct3 == F3_ILL)                   req_err = 1'b1;
        if (bus.in_store && bus.in_funct3[2])          req_err = 1'b1;
        if (misaligned(bus.in_funct3, bus.in_addr[2:0])) req_err = 1'b1;
        if (|bus.in_addr[63:AW+2])                     req_err = 1'b1;
        // Second word of a doubleword would wrap past the last word.
        if (bus.in_funct3 == F3_D && (&bus.in_addr[AW+1:2])) req_err = 1'b1;
    end

    lsu_align u_align (
        .funct3_i  (funct3_q),
        .offset_i  (off_q),
        .second_i  (state_q == ST_ISSUE1),
        .st_data_i (wdata_q),
        .st_we_o   (st_we),
        .st_word_o (st_word),
        .ld_hi_i   (hi_q),
        .ld_lo_i   (bus.mem_rdata),
        .ld_data_o (ld_data)
    );

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        word_d   = word_q;
        off_d    = off_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        err_d    = err_q;
        hi_d     = hi_q;
        data_d   = data_q;

        bus.in_ready  = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'h0;
        bus.out_valid = 1'b0;
        bus.out_wb_en = 1'b0;
        bus.out_rd    = 5'd0;
        bus.out_data  = 64'h0;
        bus.out_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    store_d  = bus.in_store;
                    funct3_d = bus.in_funct3;
                    word_d   = bus.in_addr[AW+1:2];
                    off_d    = bus.in_addr[1:0];
                    wdata_d  = bus.in_wdata;
                    rd_d     = bus.in_rd;
                    err_d    = req_err;
                    hi_d     = 32'h0;
                    data_d   = 64'h0;
                    state_d  = req_err ? ST_DONE : ST_ISSUE0;
                end
            end

            ST_ISSUE0: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = word_q;
                if (store_q) begin
                    bus.mem_we    = st_we;
                    bus.mem_wdata = st_word;
                end
                state_d = (funct3_q == F3_D) ? ST_ISSUE1 : ST_WAIT;
            end

            ST_ISSUE1: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = word_q + AW'(1);
                if (store_q) begin
                    bus.mem_we    = st_we;
                    bus.mem_wdata = st_word;
                end else begin
                    // Read data for the ISSUE0 access arrives now.
                    hi_d = bus.mem_rdata;
                end
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (!store_q) begin
                    data_d = ld_data;
                end
                state_d = ST_DONE;
            end

            ST_DONE: begin
                bus.out_valid = 1'b1;
                bus.out_err   = err_q;
                bus.out_wb_en = !store_q && !err_q;
                bus.out_rd    = rd_q;
                bus.out_data  = data_q;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            word_q   <= '0;
            off_q    <= 2'b00;
            wdata_q  <= 64'h0;
            rd_q     <= 5'd0;
            err_q    <= 1'b0;
            hi_q     <= 32'h0;
            data_q   <= 64'h0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            word_q   <= word_d;
            off_q    <= off_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            err_q    <= err_d;
            hi_q     <= hi_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit: a behavioural 4096 x 32 big-endian word
// memory with one-cycle read latency, a vector table of requests with
// hand-computed results, and hand-written sequences for backpressure and
// reset during the second word of a doubleword store.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int AW = 12;

    logic clk;
    logic rst;

    lsu_if #(.AW(AW)) bus ();

    load_store_unit #(.AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model. NOTE: the storage array has no reset; only words written
    // through the DUT are ever read back, so unknown contents are harmless.
    logic [31:0] mem [0:(1<<AW)-1];
    logic [3:0]  last_we;
    int          en_count;

    initial begin
        en_count = 0;
        last_we  = 4'b0000;
    end

    always @(posedge clk) begin
        if (bus.mem_en) begin
            en_count++;
            last_we       <= bus.mem_we;
            bus.mem_rdata <= mem[bus.mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_we[3-b]) begin
                    mem[bus.mem_addr][31-8*b -: 8] <= bus.mem_wdata[31-8*b -: 8];
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Present a request, wait (bounded) for in_ready, take the accept edge.
    task automatic send(input logic st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [4:0] rd);
        int guard;
        guard         = 0;
        bus.in_valid  = 1'b1;
        bus.in_store  = st;
        bus.in_funct3 = f3;
        bus.in_addr   = a;
        bus.in_wdata  = wd;
        bus.in_rd     = rd;
        while (!bus.in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("accept_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; latency counts that edge as cycle 1.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic        err;
        logic [63:0] data;
        int          lat;
        int          n_en;
        logic [3:0]  we;
    } vec_t;

    vec_t vecs [20];

    initial begin
        int lat;
        int en0;
        logic [63:0] held;

        vecs[0]  = '{1'b1, F3_D,   64'h400,  64'h1122334455667788, 5'd0,  1'b0, 64'h0,                4, 2, 4'b1111};
        vecs[1]  = '{1'b0, F3_D,   64'h400,  64'h0,                5'd5,  1'b0, 64'h1122334455667788, 4, 2, 4'b0000};
        vecs[2]  = '{1'b1, F3_B,   64'h403,  64'h80,               5'd0,  1'b0, 64'h0,                3, 1, 4'b0001};
        vecs[3]  = '{1'b0, F3_B,   64'h403,  64'h0,                5'd6,  1'b0, 64'hFFFFFFFFFFFFFF80, 3, 1, 4'b0000};
        vecs[4]  = '{1'b0, F3_BU,  64'h403,  64'h0,                5'd7,  1'b0, 64'h80,               3, 1, 4'b0000};
        vecs[5]  = '{1'b0, F3_H,   64'h401,  64'h0,                5'd8,  1'b1, 64'h0,                1, 0, 4'b0000};
        vecs[6]  = '{1'b1, F3_D,   64'h404,  64'h5,                5'd0,  1'b1, 64'h0,                1, 0, 4'b0000};
        vecs[7]  = '{1'b1, F3_W,   64'h3FFC, 64'hDEADBEEF,         5'd0,  1'b0, 64'h0,                3, 1, 4'b1111};
        vecs[8]  = '{1'b0, F3_W,   64'h3FFC, 64'h0,                5'd9,  1'b0, 64'hFFFFFFFFDEADBEEF, 3, 1, 4'b0000};
        vecs[9]  = '{1'b0, F3_WU,  64'h3FFC, 64'h0,                5'd10, 1'b0, 64'h00000000DEADBEEF, 3, 1, 4'b0000};
        vecs[10] = '{1'b0, F3_D,   64'h3FFC, 64'h0,                5'd11, 1'b1, 64'h0,                1, 0, 4'b0000};
        vecs[11] = '{1'b0, F3_W,   64'h4000, 64'h0,                5'd12, 1'b1, 64'h0,                1, 0, 4'b0000};
        vecs[12] = '{1'b0, F3_H,   64'h402,  64'h0,                5'd13, 1'b0, 64'h3380,             3, 1, 4'b0000};
        vecs[13] = '{1'b0, F3_HU,  64'h400,  64'h0,                5'd14, 1'b0, 64'h1122,             3, 1, 4'b0000};
        vecs[14] = '{1'b1, F3_H,   64'h406,  64'hABCD,             5'd0,  1'b0, 64'h0,                3, 1, 4'b0011};
        vecs[15] = '{1'b0, F3_H,   64'h406,  64'h0,                5'd15, 1'b0, 64'hFFFFFFFFFFFFABCD, 3, 1, 4'b0000};
        vecs[16] = '{1'b0, F3_B,   64'h404,  64'h0,                5'd16, 1'b0, 64'h55,               3, 1, 4'b0000};
        vecs[17] = '{1'b0, F3_ILL, 64'h400,  64'h0,                5'd17, 1'b1, 64'h0,                1, 0, 4'b0000};
        vecs[18] = '{1'b1, F3_BU,  64'h400,  64'h1,                5'd0,  1'b1, 64'h0,                1, 0, 4'b0000};
        vecs[19] = '{1'b1, F3_W,   64'h3FF8, 64'h0BADF00D,         5'd0,  1'b0, 64'h0,                3, 1, 4'b1111};

        bus.in_valid  = 1'b0;
        bus.in_store  = 1'b0;
        bus.in_funct3 = 3'b000;
        bus.in_addr   = 64'h0;
        bus.in_wdata  = 64'h0;
        bus.in_rd     = 5'd0;
        bus.out_ready = 1'b1;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_mem", {bus.mem_en, bus.mem_we, 20'(bus.mem_addr), bus.mem_wdata}, 64'h0);
        check("rst_out_ctl", {bus.out_valid, bus.out_wb_en, bus.out_err, bus.out_rd}, 64'h0);
        check("rst_out_data", bus.out_data, 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            en0 = en_count;
            send(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rd);
            wait_done(lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_err", i), 64'(bus.out_err), 64'(vecs[i].err));
            check($sformatf("v%0d_data", i), bus.out_data, vecs[i].data);
            check($sformatf("v%0d_wb_en", i), 64'(bus.out_wb_en),
                  64'(!vecs[i].st && !vecs[i].err));
            check($sformatf("v%0d_rd", i), 64'(bus.out_rd), 64'(vecs[i].rd));
            check($sformatf("v%0d_mem_en_count", i), 64'(en_count - en0), 64'(vecs[i].n_en));
            if (!vecs[i].err)
                check($sformatf("v%0d_mem_we", i), 64'(last_we), 64'(vecs[i].we));
            if (i == 0) begin
                check("sd_word_100", 64'(mem[12'h100]), 64'h11223344);
                check("sd_word_101", 64'(mem[12'h101]), 64'h55667788);
            end
            @(posedge clk); #1;
        end

        check("ld_last_legal", 64'h0, 64'h0 ^ 64'h0 | bus.out_data); // out_data back to 0 in IDLE
        check("mem_word_100", 64'(mem[12'h100]), 64'h11223380);
        check("mem_word_101", 64'(mem[12'h101]), 64'h5566ABCD);

        // Last legal doubleword (words 4094/4095).
        send(1'b0, F3_D, 64'h3FF8, 64'h0, 5'd20);
        wait_done(lat);
        check("ld_3ff8_latency", 64'(lat), 64'd4);
        check("ld_3ff8_data", bus.out_data, 64'h0BADF00DDEADBEEF);
        check("ld_3ff8_err", 64'(bus.out_err), 64'd0);
        @(posedge clk); #1;

        // Backpressure: completion held while out_ready is low.
        bus.out_ready = 1'b0;
        send(1'b0, F3_W, 64'h400, 64'h0, 5'd21);
        wait_done(lat);
        check("bp_latency", 64'(lat), 64'd3);
        check("bp_data", bus.out_data, 64'h11223380);
        held = bus.out_data;
        bus.in_valid  = 1'b1;
        bus.in_store  = 1'b0;
        bus.in_funct3 = F3_BU;
        bus.in_addr   = 64'h403;
        bus.in_rd     = 5'd22;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_valid", k), 64'(bus.out_valid), 64'd1);
            check($sformatf("bp_hold%0d_data", k), bus.out_data, held);
            check($sformatf("bp_hold%0d_in_ready", k), 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;  // handshake edge -> IDLE
        check("bp_after_hs_valid", 64'(bus.out_valid), 64'd0);
        check("bp_after_hs_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;  // accept edge
        bus.in_valid = 1'b0;
        check("bp_next_accepted", 64'(bus.in_ready), 64'd0);
        wait_done(lat);
        check("bp_next_latency", 64'(lat), 64'd3);
        check("bp_next_data", bus.out_data, 64'h80);
        check("bp_next_rd", 64'(bus.out_rd), 64'd22);
        @(posedge clk); #1;

        // Reset during ISSUE1 of a doubleword store.
        send(1'b1, F3_D, 64'h800, 64'h0, 5'd0);
        wait_done(lat);
        @(posedge clk); #1;
        send(1'b1, F3_D, 64'h800, 64'hCAFEF00D12345678, 5'd0);  // now in ISSUE0
        check("rs_issue0_en", 64'(bus.mem_en), 64'd1);
        @(posedge clk); #1;                                     // now in ISSUE1
        check("rs_issue1_addr", 64'(bus.mem_addr), 64'h201);
        rst = 1'b1;
        #1;
        check("rs_mem_en_drop", 64'(bus.mem_en), 64'd0);
        check("rs_idle", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) lat++;
        end
        check("rs_no_out_valid", 64'(lat), 64'd0);
        check("rs_word_200", 64'(mem[12'h200]), 64'hCAFEF00D);
        check("rs_word_201", 64'(mem[12'h201]), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
